// File: rtl/tetromino_rotator.sv
// ---------------------------------------------------------------------------
// tetromino_rotator
//
// Holds the active falling piece (shape code from the piece selector) and its
// committed rotation. A rotate key press produces one rotation request with a
// registered candidate cell set; the playfield collision checker answers over
// a req/ack handshake and the rotation is committed only when it is allowed.
// A request that gets no answer within ACK_TIMEOUT cycles is treated as denied.
// Cell coordinates are in bounding-box space, y grows downward, 2 bits per
// coordinate, cell k packed at [2k+1:2k].
//
// Ports
//   Clk          in   1   clock
//   Reset        in   1   asynchronous, active-high reset
//   shape_num    in   3   1=I 2=O 3=T 4=S 5=Z 6=J 7=L, 0=none
//   spawn        in   1   pulse: latch shape_num as the new active piece
//   keycode      in   16  current key code, 0 = no key
//   rot_ack      in   1   collision checker answer valid (looked at only while rot_req=1)
//   rot_allow    in   1   with rot_ack: 1 = candidate fits
//   rot_req      out  1   rotation request pending, cand_x/cand_y stable
//   cand_x/y     out  8   candidate cells
//   cell_x/y     out  8   committed cells
//   cur_shape    out  3   latched shape, 0 when no piece
//   rot_idx      out  2   committed rotation, +1 per clockwise step
//   piece_valid  out  1   a piece is active
//
// state    | meaning
// IDLE     | no active piece, waiting for a spawn with a non-zero shape
// READY    | piece active, waiting for a rotate key
// WAIT_ACK | request issued, waiting for the collision checker or the timeout
// WAIT_REL | waiting for the rotate key to be released (one step per press)
// ---------------------------------------------------------------------------
module tetromino_rotator #(
  parameter logic [15:0] ROT_CW_KEY  = 16'h001A,
  parameter logic [15:0] ROT_CCW_KEY = 16'h0008,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  shape_num,
  input  logic        spawn,
  input  logic [15:0] keycode,
  input  logic        rot_ack,
  input  logic        rot_allow,
  output logic        rot_req,
  output logic [7:0]  cand_x,
  output logic [7:0]  cand_y,
  output logic [7:0]  cell_x,
  output logic [7:0]  cell_y,
  output logic [2:0]  cur_shape,
  output logic [1:0]  rot_idx,
  output logic        piece_valid
);

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [2:0] SHAPE_NONE = 3'd0;
  localparam logic [2:0] SHAPE_I    = 3'd1;
  localparam logic [2:0] SHAPE_O    = 3'd2;
  localparam logic [2:0] SHAPE_T    = 3'd3;
  localparam logic [2:0] SHAPE_S    = 3'd4;
  localparam logic [2:0] SHAPE_Z    = 3'd5;
  localparam logic [2:0] SHAPE_J    = 3'd6;
  localparam logic [2:0] SHAPE_L    = 3'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    WAIT_ACK = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  // Returns {y[7:0], x[7:0]} for a shape in a given rotation. The base table
  // is the spawn orientation; each clockwise step maps (x,y) -> (N-1-y, x)
  // inside the N x N bounding box. O never moves, shape 0 has no cells.
  function automatic logic [15:0] piece_cells(input logic [2:0] shape,
                                              input logic [1:0] rot);
    logic [7:0] px;
    logic [7:0] py;
    logic [1:0] lim;
    logic [1:0] tx;
    px = 8'h00;
    py = 8'h00;
    case (shape)
      SHAPE_I: begin px = 8'hE4; py = 8'h55; end
      SHAPE_O: begin px = 8'h99; py = 8'h50; end
      SHAPE_T: begin px = 8'h91; py = 8'h54; end
      SHAPE_S: begin px = 8'h49; py = 8'h50; end
      SHAPE_Z: begin px = 8'h94; py = 8'h50; end
      SHAPE_J: begin px = 8'h90; py = 8'h54; end
      SHAPE_L: begin px = 8'h92; py = 8'h54; end
      default: begin px = 8'h00; py = 8'h00; end
    endcase
    lim = (shape == SHAPE_I) ? 2'd3 : 2'd2;
    for (int r = 0; r < 3; r++) begin
      if ((r < int'(rot)) && (shape != SHAPE_O) && (shape != SHAPE_NONE)) begin
        for (int k = 0; k < 4; k++) begin
          tx              = px[2*k +: 2];
          px[2*k +: 2]    = lim - py[2*k +: 2];
          py[2*k +: 2]    = tx;
        end
      end
    end
    return {py, px};
  endfunction

  state_t          state_q,     state_d;
  logic [2:0]      cur_shape_q, cur_shape_d;
  logic [1:0]      rot_idx_q,   rot_idx_d;
  logic [1:0]      cand_rot_q,  cand_rot_d;
  logic [7:0]      cand_x_q,    cand_x_d;
  logic [7:0]      cand_y_q,    cand_y_d;
  logic            rot_req_q,   rot_req_d;
  logic [TW-1:0]   timer_q,     timer_d;

  logic            key_cw;
  logic            key_ccw;
  logic [1:0]      step_rot;
  logic [15:0]     step_cells;
  logic [15:0]     cur_cells;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cur_shape_q <= 3'd0;
      rot_idx_q   <= 2'd0;
      cand_rot_q  <= 2'd0;
      cand_x_q    <= 8'h00;
      cand_y_q    <= 8'h00;
      rot_req_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_shape_q <= cur_shape_d;
      rot_idx_q   <= rot_idx_d;
      cand_rot_q  <= cand_rot_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      rot_req_q   <= rot_req_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    key_cw     = (keycode == ROT_CW_KEY);
    key_ccw    = (keycode == ROT_CCW_KEY);
    step_rot   = key_cw ? (rot_idx_q + 2'd1) : (rot_idx_q - 2'd1);
    step_cells = piece_cells(cur_shape_q, step_rot);
    cur_cells  = piece_cells(cur_shape_q, rot_idx_q);
  end

  always_comb begin
    state_d     = state_q;
    cur_shape_d = cur_shape_q;
    rot_idx_d   = rot_idx_q;
    cand_rot_d  = cand_rot_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    rot_req_d   = rot_req_q;
    timer_d     = timer_q;

    // A spawn on an active piece wins over everything, including an ack
    // arriving on the same edge.
    if (spawn && (state_q != IDLE)) begin
      rot_req_d = 1'b0;
      timer_d   = '0;
      state_d   = WAIT_REL;
      if (shape_num != SHAPE_NONE) begin
        cur_shape_d = shape_num;
        rot_idx_d   = 2'd0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (spawn && (shape_num != SHAPE_NONE)) begin
            cur_shape_d = shape_num;
            rot_idx_d   = 2'd0;
            state_d     = WAIT_REL;
          end
        end
        READY: begin
          if (key_cw || key_ccw) begin
            cand_rot_d = step_rot;
            cand_x_d   = step_cells[7:0];
            cand_y_d   = step_cells[15:8];
            rot_req_d  = 1'b1;
            timer_d    = '0;
            state_d    = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (rot_ack) begin
            if (rot_allow) begin
              rot_idx_d = cand_rot_q;
            end
            rot_req_d = 1'b0;
            state_d   = WAIT_REL;
          end else if (timer_q == TIMER_LAST) begin
            rot_req_d = 1'b0;
            state_d   = WAIT_REL;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!key_cw && !key_ccw) begin
            state_d = READY;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Committed cells follow directly from the registered shape and rotation,
  // so they change on the same edge as rot_idx.
  assign cell_x      = cur_cells[7:0];
  assign cell_y      = cur_cells[15:8];
  assign cand_x      = cand_x_q;
  assign cand_y      = cand_y_q;
  assign rot_req     = rot_req_q;
  assign cur_shape   = cur_shape_q;
  assign rot_idx     = rot_idx_q;
  assign piece_valid = (state_q != IDLE);

endmodule

// File: tb/tb_tetromino_rotator.sv
module tb_tetromino_rotator;

  localparam logic [15:0] CW  = 16'h001A;
  localparam logic [15:0] CCW = 16'h0008;

  logic        Clk;
  logic        Reset;
  logic [2:0]  shape_num;
  logic        spawn;
  logic [15:0] keycode;
  logic        rot_ack;
  logic        rot_allow;
  logic        rot_req;
  logic [7:0]  cand_x;
  logic [7:0]  cand_y;
  logic [7:0]  cell_x;
  logic [7:0]  cell_y;
  logic [2:0]  cur_shape;
  logic [1:0]  rot_idx;
  logic        piece_valid;

  int checks = 0;
  int errors = 0;

  tetromino_rotator #(
    .ROT_CW_KEY (16'h001A),
    .ROT_CCW_KEY(16'h0008),
    .ACK_TIMEOUT(16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .shape_num  (shape_num),
    .spawn      (spawn),
    .keycode    (keycode),
    .rot_ack    (rot_ack),
    .rot_allow  (rot_allow),
    .rot_req    (rot_req),
    .cand_x     (cand_x),
    .cand_y     (cand_y),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .cur_shape  (cur_shape),
    .rot_idx    (rot_idx),
    .piece_valid(piece_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_spawn(input logic [2:0] s);
    shape_num = s;
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
    shape_num = 3'd0;
  endtask

  // Press key, answer on the next cycle, release; ends in READY.
  task automatic do_rotate(input logic [15:0] key, input logic allow);
    keycode = key;
    tick();
    rot_ack = 1'b1;
    rot_allow = allow;
    tick();
    rot_ack = 1'b0;
    rot_allow = 1'b0;
    keycode = 16'h0000;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    checks++; if (rot_req !== 1'b0) begin errors++; $display("FAIL reset_rot_req: got %b expected 0", rot_req); end
    checks++; if (piece_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", piece_valid); end
    checks++; if ({cur_shape, rot_idx} !== 5'd0) begin errors++; $display("FAIL reset_shape_rot: got %h expected 0", {cur_shape, rot_idx}); end
    checks++; if ({cell_x, cell_y, cand_x, cand_y} !== 32'h0) begin errors++; $display("FAIL reset_cells: got %h expected 0", {cell_x, cell_y, cand_x, cand_y}); end
    // spawn with shape 0 in IDLE is ignored
    do_spawn(3'd0);
    checks++; if (piece_valid !== 1'b0) begin errors++; $display("FAIL spawn0_idle: got %b expected 0", piece_valid); end
  endtask

  task automatic test_spawn_t();
    do_spawn(3'd3);
    checks++; if (piece_valid !== 1'b1) begin errors++; $display("FAIL spawn_t_valid: got %b expected 1", piece_valid); end
    checks++; if (cur_shape !== 3'd3) begin errors++; $display("FAIL spawn_t_shape: got %0d expected 3", cur_shape); end
    checks++; if (rot_idx !== 2'd0) begin errors++; $display("FAIL spawn_t_rot: got %0d expected 0", rot_idx); end
    checks++; if ({cell_x, cell_y} !== 16'h9154) begin errors++; $display("FAIL spawn_t_cells: got %h expected 9154", {cell_x, cell_y}); end
    tick();
  endtask

  task automatic test_cw_grant();
    int high;
    logic held;
    high = 0;
    held = 1'b1;
    keycode = CW;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rot_req === 1'b1) high++;
      if ({cand_x, cand_y} !== 16'h5691) held = 1'b0;
    end
    rot_ack = 1'b1;
    rot_allow = 1'b1;
    tick();
    rot_ack = 1'b0;
    rot_allow = 1'b0;
    checks++; if (high !== 3) begin errors++; $display("FAIL cw_req_cycles: got %0d expected 3", high); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL cw_cand_held: got %h expected 5691", {cand_x, cand_y}); end
    checks++; if (rot_req !== 1'b0) begin errors++; $display("FAIL cw_req_drop: got %b expected 0", rot_req); end
    checks++; if (rot_idx !== 2'd1) begin errors++; $display("FAIL cw_rot: got %0d expected 1", rot_idx); end
    checks++; if ({cell_x, cell_y} !== 16'h5691) begin errors++; $display("FAIL cw_cells: got %h expected 5691", {cell_x, cell_y}); end
    keycode = 16'h0000;
    tick();
  endtask

  task automatic test_deny_then_grant();
    do_spawn(3'd1);
    tick();
    do_rotate(CW, 1'b0);
    checks++; if (rot_idx !== 2'd0) begin errors++; $display("FAIL deny_rot: got %0d expected 0", rot_idx); end
    checks++; if ({cell_x, cell_y} !== 16'hE455) begin errors++; $display("FAIL deny_cells: got %h expected E455", {cell_x, cell_y}); end
    // a stray ack with no request pending changes nothing
    rot_ack = 1'b1;
    rot_allow = 1'b1;
    tick();
    rot_ack = 1'b0;
    rot_allow = 1'b0;
    checks++; if ({rot_req, rot_idx} !== 3'b000) begin errors++; $display("FAIL stray_ack: got %b expected 000", {rot_req, rot_idx}); end
    do_rotate(CW, 1'b1);
    checks++; if (rot_idx !== 2'd1) begin errors++; $display("FAIL grant_i_rot: got %0d expected 1", rot_idx); end
    checks++; if ({cell_x, cell_y} !== 16'hAAE4) begin errors++; $display("FAIL grant_i_cells: got %h expected AAE4", {cell_x, cell_y}); end
  endtask

  task automatic test_hold_one_step();
    int high;
    high = 0;
    do_spawn(3'd3);
    tick();
    keycode = CW;
    rot_ack = 1'b1;
    rot_allow = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rot_req === 1'b1) high++;
    end
    rot_ack = 1'b0;
    rot_allow = 1'b0;
    checks++; if (high !== 1) begin errors++; $display("FAIL hold_req_count: got %0d expected 1", high); end
    checks++; if (rot_idx !== 2'd1) begin errors++; $display("FAIL hold_rot: got %0d expected 1", rot_idx); end
    keycode = 16'h0000;
    tick();
    do_rotate(CCW, 1'b1);
    checks++; if (rot_idx !== 2'd0) begin errors++; $display("FAIL ccw_back_rot: got %0d expected 0", rot_idx); end
    checks++; if ({cell_x, cell_y} !== 16'h9154) begin errors++; $display("FAIL ccw_back_cells: got %h expected 9154", {cell_x, cell_y}); end
    do_rotate(CCW, 1'b1);
    checks++; if (rot_idx !== 2'd3) begin errors++; $display("FAIL ccw_wrap_rot: got %0d expected 3", rot_idx); end
    checks++; if ({cell_x, cell_y} !== 16'h5419) begin errors++; $display("FAIL ccw_wrap_cells: got %h expected 5419", {cell_x, cell_y}); end
  endtask

  task automatic test_timeout();
    int cnt;
    cnt = 0;
    keycode = CW;
    tick();
    while (rot_req === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++; if (cnt !== 16) begin errors++; $display("FAIL timeout_cycles: got %0d expected 16", cnt); end
    checks++; if (rot_idx !== 2'd3) begin errors++; $display("FAIL timeout_rot: got %0d expected 3", rot_idx); end
    checks++; if ({cell_x, cell_y} !== 16'h5419) begin errors++; $display("FAIL timeout_cells: got %h expected 5419", {cell_x, cell_y}); end
    keycode = 16'h0000;
    tick();
  endtask

  task automatic test_spawn_vs_ack();
    keycode = CW;
    tick();
    checks++; if (rot_req !== 1'b1) begin errors++; $display("FAIL pre_spawn_req: got %b expected 1", rot_req); end
    shape_num = 3'd2;
    spawn = 1'b1;
    rot_ack = 1'b1;
    rot_allow = 1'b1;
    tick();
    spawn = 1'b0;
    shape_num = 3'd0;
    rot_ack = 1'b0;
    rot_allow = 1'b0;
    checks++; if (rot_req !== 1'b0) begin errors++; $display("FAIL spawn_ack_req: got %b expected 0", rot_req); end
    checks++; if ({cur_shape, rot_idx} !== 5'b010_00) begin errors++; $display("FAIL spawn_ack_shape_rot: got %b expected 01000", {cur_shape, rot_idx}); end
    checks++; if ({cell_x, cell_y} !== 16'h9950) begin errors++; $display("FAIL spawn_ack_cells: got %h expected 9950", {cell_x, cell_y}); end
    keycode = 16'h0000;
    tick();
    // spawn of shape 0 on an active piece aborts the request only
    keycode = CW;
    tick();
    do_spawn(3'd0);
    checks++; if ({rot_req, piece_valid, cur_shape} !== 5'b0_1_010) begin errors++; $display("FAIL spawn0_abort: got %b expected 01010", {rot_req, piece_valid, cur_shape}); end
    keycode = 16'h0000;
    tick();
    // O rotation: rot_idx advances, cells unchanged
    do_rotate(CW, 1'b1);
    checks++; if (rot_idx !== 2'd1) begin errors++; $display("FAIL o_rot: got %0d expected 1", rot_idx); end
    checks++; if ({cell_x, cell_y} !== 16'h9950) begin errors++; $display("FAIL o_cells: got %h expected 9950", {cell_x, cell_y}); end
  endtask

  task automatic test_reset_mid_ack();
    keycode = CW;
    tick();
    checks++; if (rot_req !== 1'b1) begin errors++; $display("FAIL mid_ack_req: got %b expected 1", rot_req); end
    #2;
    Reset = 1'b1;
    #1;
    checks++; if ({rot_req, piece_valid, cur_shape, rot_idx} !== 7'd0) begin errors++; $display("FAIL async_reset_ctl: got %b expected 0", {rot_req, piece_valid, cur_shape, rot_idx}); end
    checks++; if ({cell_x, cell_y, cand_x, cand_y} !== 32'h0) begin errors++; $display("FAIL async_reset_cells: got %h expected 0", {cell_x, cell_y, cand_x, cand_y}); end
    keycode = 16'h0000;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    shape_num = 3'd0;
    spawn = 1'b0;
    keycode = 16'h0000;
    rot_ack = 1'b0;
    rot_allow = 1'b0;
    test_reset();
    test_spawn_t();
    test_cw_grant();
    test_deny_then_grant();
    test_hold_one_step();
    test_timeout();
    test_spawn_vs_ack();
    test_reset_mid_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
